// File: rtl/fir_pipe_if.sv
// ---------------------------------------------------------------------------
// fir_pipe_if -- sample stream bundle for the pipelined FIR filter.
//   data_in  : signed IN_WL-bit sample x[n], one per clock, no handshake
//   data_out : signed OUT_WL-bit filtered sample y[n], one per clock
// Modports:
//   master : sample source / result sink (drives data_in)
//   slave  : the filter (drives data_out)
// ---------------------------------------------------------------------------
interface fir_pipe_if #(
  parameter int IN_WL  = 15,
  parameter int OUT_WL = 20
);
  logic signed [IN_WL-1:0]  data_in;
  logic signed [OUT_WL-1:0] data_out;

  modport master (output data_in, input data_out);
  modport slave  (input data_in, output data_out);
endinterface

// File: rtl/fir_pipe.sv
// ---------------------------------------------------------------------------
// fir_pipe -- fully pipelined direct-form FIR filter.
//   y[n] = sat_OUT_WL( floor( sum_k h[k]*x[n-k] / 2^SHIFT ) )
// Structure: input register / tap delay line -> registered full-precision
// products -> registered binary adder tree (one bit of growth per level)
// -> registered shift+saturate -> balancing delay chain to reach LATENCY.
// Ports:
//   clk : single clock, all state updates on the rising edge
//   rst : synchronous active-high reset, clears every register
//   bus : fir_pipe_if.slave (data_in sampled every edge, data_out registered)
// ---------------------------------------------------------------------------
module fir_pipe #(
  parameter int IN_WL   = 15,
  parameter int OUT_WL  = 20,
  parameter int TAPS    = 16,
  parameter int COEF_WL = 15,
  // h[0] sits in the least significant COEF_WL bits and multiplies the newest sample
  parameter logic [TAPS*COEF_WL-1:0] COEFS = {
    15'sd0,    -15'sd12, 15'sd0,   15'sd58,  15'sd0,   -15'sd161, 15'sd0,   15'sd619,
    15'sd1024, 15'sd619, 15'sd0,  -15'sd161, 15'sd0,    15'sd58,  15'sd0,  -15'sd12
  },
  parameter int SHIFT   = 10,
  parameter int LATENCY = 35
) (
  input  logic       clk,
  input  logic       rst,
  fir_pipe_if.slave  bus
);

  localparam int PW     = IN_WL + COEF_WL;                 // full product width
  localparam int LEVELS = (TAPS > 1) ? $clog2(TAPS) : 1;  // adder tree depth
  localparam int NPAD   = 1 << LEVELS;                     // taps padded to a power of two
  localparam int SW     = PW + LEVELS;                     // width of the final sum
  // Stages: tap register, product register, LEVELS tree registers and the
  // saturate register; the remainder of LATENCY is plain balancing delay.
  localparam int NBAL   = LATENCY - LEVELS - 2;

  // Saturation bounds expressed at sum width (the sum is always wider than the output)
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-OUT_WL+1){1'b0}}, {(OUT_WL-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-OUT_WL+1){1'b1}}, {(OUT_WL-1){1'b0}}};

  logic signed [IN_WL-1:0]  r_tap  [0:TAPS-1];
  // Level 0 holds the products; level l holds partial sums that fit in PW+l
  // bits, all kept sign-extended at SW bits so no intermediate rounding happens.
  logic signed [SW-1:0]     r_tree [0:LEVELS][0:NPAD-1];
  logic signed [OUT_WL-1:0] r_pipe [0:NBAL];
  logic signed [PW-1:0]     w_prod [0:TAPS-1];
  logic signed [SW-1:0]     w_shift;
  logic signed [OUT_WL-1:0] w_sat;

  function automatic logic signed [COEF_WL-1:0] coef(input int k);
    return COEFS[k*COEF_WL +: COEF_WL];
  endfunction

  // Full-precision products, then floor shift and clamp of the finished sum
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      w_prod[k] = PW'(r_tap[k]) * PW'(coef(k));
    end
    w_shift = r_tree[LEVELS][0] >>> SHIFT;  // arithmetic shift = floor division
    if (w_shift > SAT_MAX) begin
      w_sat = SAT_MAX[OUT_WL-1:0];
    end else if (w_shift < SAT_MIN) begin
      w_sat = SAT_MIN[OUT_WL-1:0];
    end else begin
      w_sat = w_shift[OUT_WL-1:0];
    end
  end

  // Pipeline registers: delay line, products, adder tree, output and balancing chain
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        r_tap[k] <= '0;
      end
      for (int l = 0; l <= LEVELS; l++) begin
        for (int i = 0; i < NPAD; i++) begin
          r_tree[l][i] <= '0;
        end
      end
      for (int j = 0; j <= NBAL; j++) begin
        r_pipe[j] <= '0;
      end
    end else begin
      // r_tap[0] is the input register; after edge n, r_tap[k] holds x[n-k]
      r_tap[0] <= bus.data_in;
      for (int k = 1; k < TAPS; k++) begin
        r_tap[k] <= r_tap[k-1];
      end
      for (int k = 0; k < TAPS; k++) begin
        r_tree[0][k] <= SW'(w_prod[k]);
      end
      for (int k = TAPS; k < NPAD; k++) begin
        r_tree[0][k] <= '0;
      end
      for (int l = 1; l <= LEVELS; l++) begin
        for (int i = 0; i < (NPAD >> l); i++) begin
          r_tree[l][i] <= r_tree[l-1][2*i] + r_tree[l-1][2*i+1];
        end
        for (int i = (NPAD >> l); i < NPAD; i++) begin
          r_tree[l][i] <= '0;
        end
      end
      r_pipe[0] <= w_sat;
      for (int j = 1; j <= NBAL; j++) begin
        r_pipe[j] <= r_pipe[j-1];
      end
    end
  end

  assign bus.data_out = r_pipe[NBAL];

endmodule

// File: tb/tb_fir_pipe.sv
// ---------------------------------------------------------------------------
// tb_fir_pipe -- self-checking bench for fir_pipe with default parameters.
// A behavioural model recomputes y[n] as a plain convolution over the
// recorded input history, honouring resets, and every edge's output is
// compared against it; impulse and hold scenarios also check fixed values.
// ---------------------------------------------------------------------------
module tb_fir_pipe;

  localparam int LAT = 35;
  localparam int NT  = 16;
  localparam int H [NT] = '{-12, 0, 58, 0, -161, 0, 619, 1024, 619, 0, -161, 0, 58, 0, -12, 0};
  // floor(-h[k] / 1024) for an x = -1 impulse
  localparam int HNEG [NT] = '{0, 0, -1, 0, 0, 0, -1, -1, -1, 0, 0, 0, -1, 0, 0, 0};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_pipe_if #(.IN_WL(15), .OUT_WL(20)) bus ();

  fir_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int xs [$];   // sample presented at each edge
  bit rs [$];   // rst value at each edge
  int n_vec = 0;
  int n_err = 0;

  // Apply one edge worth of inputs, record it, and return #1 after the edge
  task automatic drive(input int x, input bit r);
    bus.data_in = 15'(x);
    rst = r;
    @(posedge clk);
    xs.push_back(x);
    rs.push_back(r);
    #1;
  endtask

  function automatic int rand_sample();
    return int'($urandom_range(32767, 0)) - 16384;
  endfunction

  // Expected data_out after edge e
  function automatic int model(input int e);
    longint acc;
    int m;
    // Any reset in the last LATENCY+1 edges means nothing has come through yet
    for (int j = e - LAT; j <= e; j++) begin
      if (j < 0 || rs[j]) return 0;
    end
    m = e - LAT;
    acc = 0;
    for (int k = 0; k < NT; k++) begin
      if (m - k < 0 || rs[m-k]) break;  // history before a reset counts as zero
      acc += longint'(H[k]) * longint'(xs[m-k]);
    end
    acc = acc >>> 10;
    if (acc > 524287) acc = 524287;
    if (acc < -524288) acc = -524288;
    return int'(acc);
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      drive(rand_sample(), 1'b1);
      n_vec++;
      if (bus.data_out !== 20'sd0) begin
        n_err++;
        $display("FAIL reset cycle %0d: got %0d expected 0", i, bus.data_out);
      end
    end
  endtask

  task automatic test_impulse();
    int e0, d, exp_v;
    drive(0, 1'b1);
    e0 = xs.size();
    drive(1024, 1'b0);
    for (int i = 0; i < 56; i++) begin
      if (i > 0) drive(0, 1'b0);
      d = (xs.size() - 1) - e0 - LAT;
      exp_v = (d >= 0 && d < NT) ? H[d] : 0;
      n_vec++;
      if (bus.data_out !== 20'(exp_v)) begin
        n_err++;
        $display("FAIL impulse offset %0d: got %0d expected %0d", d, bus.data_out, exp_v);
      end
    end
  endtask

  task automatic test_floor_impulse();
    int e0, d, exp_v;
    drive(0, 1'b1);
    e0 = xs.size();
    drive(-1, 1'b0);
    for (int i = 0; i < 56; i++) begin
      if (i > 0) drive(0, 1'b0);
      d = (xs.size() - 1) - e0 - LAT;
      exp_v = (d >= 0 && d < NT) ? HNEG[d] : 0;
      n_vec++;
      if (bus.data_out !== 20'(exp_v)) begin
        n_err++;
        $display("FAIL floor_impulse offset %0d: got %0d expected %0d", d, bus.data_out, exp_v);
      end
    end
  endtask

  // Constant input: ramp through partial sums, then a fixed steady value
  task automatic test_hold(input int x, input int steady);
    int e0, d, exp_v;
    drive(0, 1'b1);
    e0 = xs.size();
    for (int i = 0; i < 60; i++) begin
      drive(x, 1'b0);
      d = (xs.size() - 1) - e0 - LAT;
      exp_v = (d >= NT - 1) ? steady : model(xs.size() - 1);
      n_vec++;
      if (bus.data_out !== 20'(exp_v)) begin
        n_err++;
        $display("FAIL hold x=%0d offset %0d: got %0d expected %0d", x, d, bus.data_out, exp_v);
      end
    end
  endtask

  task automatic test_midstream_reset();
    int exp_v;
    drive(0, 1'b1);
    for (int i = 0; i < 200; i++) begin
      drive(rand_sample(), (i == 99) ? 1'b1 : 1'b0);
      exp_v = model(xs.size() - 1);
      n_vec++;
      if (bus.data_out !== 20'(exp_v)) begin
        n_err++;
        $display("FAIL midstream_reset step %0d: got %0d expected %0d", i, bus.data_out, exp_v);
      end
    end
  endtask

  task automatic test_golden();
    int exp_v, x;
    drive(0, 1'b1);
    for (int i = 0; i < 540; i++) begin
      if (i >= 500)          x = 0;
      else if (i % 97 == 5)  x = -16384;
      else if (i % 89 == 7)  x = 16383;
      else                   x = rand_sample();
      drive(x, 1'b0);
      exp_v = model(xs.size() - 1);
      n_vec++;
      if (bus.data_out !== 20'(exp_v)) begin
        n_err++;
        $display("FAIL golden step %0d: got %0d expected %0d", i, bus.data_out, exp_v);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.data_in = '0;
    test_reset();
    test_impulse();
    test_floor_impulse();
    test_hold(1024, 2032);
    test_hold(-16384, -32512);
    test_midstream_reset();
    test_golden();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
